// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: owns the CSR write port, sequencing trap entry, mret and pipeline CSR writes
module csr_trap_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mstatus_rd,
  input  logic [XLEN-1:0] mtvec_rd,
  input  logic [XLEN-1:0] mepc_rd,
  input  logic            pipe_csr_we,
  input  logic [4:0]      pipe_csr_index,
  input  logic [XLEN-1:0] pipe_csr_wdata,
  output logic            pipe_csr_gnt,
  output logic            csr_we,
  output logic [4:0]      csr_windex,
  output logic [XLEN-1:0] csr_wdata,
  output logic            trap_ack,
  output logic            mret_ack,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);
  typedef enum logic [2:0] {IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_DONE, M_STATUS, M_DONE} state_t;
  state_t state;
  logic [XLEN-1:0] pc_q, cause_q, tval_q;
  logic [XLEN-1:0] trap_status, mret_status, trap_target;
  logic idle;
  // mstatus images: trap stacks MIE into MPIE, mret unstacks it; both force MPP to machine mode
  assign trap_status = {mstatus_rd[XLEN-1:13], 2'b11, mstatus_rd[10:8], mstatus_rd[3], mstatus_rd[6:4], 1'b0, mstatus_rd[2:0]};
  assign mret_status = {mstatus_rd[XLEN-1:13], 2'b11, mstatus_rd[10:8], 1'b1, mstatus_rd[6:4], mstatus_rd[7], mstatus_rd[2:0]};
  assign trap_target = {mtvec_rd[XLEN-1:2], 2'b00}
                     + ((mtvec_rd[1:0] == 2'b01 && cause_q[XLEN-1]) ? {cause_q[XLEN-3:0], 2'b00} : '0);
  assign busy = state != IDLE;
  // Sequencer state and latched trap context; arbitration trap > mret in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_req) begin
            pc_q    <= trap_pc;
            cause_q <= trap_cause;
            tval_q  <= trap_tval;
            state   <= T_EPC;
          end else if (mret_req) state <= M_STATUS;
        end
        T_EPC:    state <= T_CAUSE;
        T_CAUSE:  state <= T_TVAL;
        T_TVAL:   state <= T_STATUS;
        T_STATUS: state <= T_DONE;
        T_DONE:   state <= IDLE;
        M_STATUS: state <= M_DONE;
        M_DONE:   state <= IDLE;
      endcase
    end
  end
  // Write port and handshake decode; the pipeline only reaches the port in an uncontested IDLE cycle
  always_comb begin
    idle           = rst_n && state == IDLE;
    pipe_csr_gnt   = idle && !trap_req && !mret_req && pipe_csr_we;
    csr_we         = 1'b0;
    csr_windex     = '0;
    csr_wdata      = '0;
    trap_ack       = 1'b0;
    mret_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        csr_we     = pipe_csr_gnt && |pipe_csr_index;
        csr_windex = pipe_csr_gnt ? pipe_csr_index : '0;
        csr_wdata  = pipe_csr_gnt ? pipe_csr_wdata : '0;
      end
      T_EPC: begin
        csr_we     = 1'b1;
        csr_windex = 5'h0B;
        csr_wdata  = {pc_q[XLEN-1:2], 2'b00};
      end
      T_CAUSE: begin
        csr_we     = 1'b1;
        csr_windex = 5'h0C;
        csr_wdata  = cause_q;
      end
      T_TVAL: begin
        csr_we     = 1'b1;
        csr_windex = 5'h0D;
        csr_wdata  = tval_q;
      end
      T_STATUS: begin
        csr_we     = 1'b1;
        csr_windex = 5'h05;
        csr_wdata  = trap_status;
      end
      T_DONE: begin
        trap_ack       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = trap_target;
      end
      M_STATUS: begin
        csr_we     = 1'b1;
        csr_windex = 5'h05;
        csr_wdata  = mret_status;
      end
      M_DONE: begin
        mret_ack       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mepc_rd;
      end
    endcase
  end
endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb_csr_trap_sequencer: directed checks of arbitration, trap/mret sequences and reset
module tb_csr_trap_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_req, mret_req, pipe_csr_we;
  logic [31:0] trap_pc, trap_cause, trap_tval, mstatus_rd, mtvec_rd, mepc_rd, pipe_csr_wdata;
  logic [4:0]  pipe_csr_index;
  logic        pipe_csr_gnt, csr_we, trap_ack, mret_ack, redirect_valid, busy;
  logic [4:0]  csr_windex;
  logic [31:0] csr_wdata, redirect_pc;
  int checks = 0;
  int errors = 0;

  csr_trap_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_tval(trap_tval), .mret_req(mret_req), .mstatus_rd(mstatus_rd), .mtvec_rd(mtvec_rd),
    .mepc_rd(mepc_rd), .pipe_csr_we(pipe_csr_we), .pipe_csr_index(pipe_csr_index),
    .pipe_csr_wdata(pipe_csr_wdata), .pipe_csr_gnt(pipe_csr_gnt), .csr_we(csr_we),
    .csr_windex(csr_windex), .csr_wdata(csr_wdata), .trap_ack(trap_ack), .mret_ack(mret_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write(input string tag, input logic [4:0] idx, input logic [31:0] data);
    chk({tag, "_we"}, {31'd0, csr_we}, 32'd1);
    chk({tag, "_idx"}, {27'd0, csr_windex}, {27'd0, idx});
    chk({tag, "_data"}, csr_wdata, data);
    chk({tag, "_gnt"}, {31'd0, pipe_csr_gnt}, 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_all"}, {pipe_csr_gnt, csr_we, trap_ack, mret_ack, redirect_valid, busy, csr_windex, 21'd0},
        32'd0);
    chk({tag, "_wdata"}, csr_wdata, 32'd0);
    chk({tag, "_rpc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; trap_req = 1'b0; mret_req = 1'b0; pipe_csr_we = 1'b1; pipe_csr_index = 5'h0B;
    pipe_csr_wdata = 32'h1234; trap_pc = '0; trap_cause = '0; trap_tval = '0;
    mstatus_rd = 32'h8; mtvec_rd = 32'h8000_1001; mepc_rd = 32'h8000_0100;
    #12;
    chk_quiet("reset_hold");
    step();
    rst_n = 1'b1;
    #1;
    chk("pipe_gnt", {31'd0, pipe_csr_gnt}, 32'd1);
    chk("pipe_we", {31'd0, csr_we}, 32'd1);
    chk("pipe_idx", {27'd0, csr_windex}, 32'h0B);
    chk("pipe_data", csr_wdata, 32'h1234);
    pipe_csr_index = 5'h00;
    #1;
    chk("pipe0_gnt", {31'd0, pipe_csr_gnt}, 32'd1);
    chk("pipe0_we", {31'd0, csr_we}, 32'd0);
    pipe_csr_we = 1'b0;
    // exception trap, direct mode
    step();
    trap_req = 1'b1; trap_pc = 32'h8000_0102; trap_cause = 32'h2; trap_tval = 32'hDEAD;
    #1;
    chk("trapN_busy", {31'd0, busy}, 32'd0);
    chk("trapN_we", {31'd0, csr_we}, 32'd0);
    step(); chk_write("t_epc", 5'h0B, 32'h8000_0100);
    chk("t_epc_busy", {31'd0, busy}, 32'd1);
    step(); chk_write("t_cause", 5'h0C, 32'h2);
    step(); chk_write("t_tval", 5'h0D, 32'hDEAD);
    step(); chk_write("t_status", 5'h05, 32'h1880);
    step();
    chk("t_done_ack", {31'd0, trap_ack}, 32'd1);
    chk("t_done_rv", {31'd0, redirect_valid}, 32'd1);
    chk("t_done_rpc", redirect_pc, 32'h8000_1000);
    chk("t_done_we", {31'd0, csr_we}, 32'd0);
    trap_req = 1'b0;
    step(); chk_quiet("t_after");
    // interrupt trap, vectored mode
    trap_req = 1'b1; trap_cause = 32'h8000_0007;
    step(); step();
    chk_write("irq_cause", 5'h0C, 32'h8000_0007);
    step(); step(); step();
    chk("irq_ack", {31'd0, trap_ack}, 32'd1);
    chk("irq_rpc", redirect_pc, 32'h8000_101C);
    trap_req = 1'b0;
    // trap + mret + pipe in the same IDLE cycle
    step();
    trap_req = 1'b1; trap_cause = 32'h2; mret_req = 1'b1;
    pipe_csr_we = 1'b1; pipe_csr_index = 5'h0C; pipe_csr_wdata = 32'h55;
    #1;
    chk("arb_gnt0", {31'd0, pipe_csr_gnt}, 32'd0);
    chk("arb_we0", {31'd0, csr_we}, 32'd0);
    step(); chk_write("arb_epc", 5'h0B, 32'h8000_0100);
    step(); chk_write("arb_cause", 5'h0C, 32'h2);
    step(); chk_write("arb_tval", 5'h0D, 32'hDEAD);
    step(); chk_write("arb_status", 5'h05, 32'h1880);
    mstatus_rd = 32'h1880;
    step();
    chk("arb_tack", {31'd0, trap_ack}, 32'd1);
    chk("arb_mack0", {31'd0, mret_ack}, 32'd0);
    chk("arb_done_gnt", {31'd0, pipe_csr_gnt}, 32'd0);
    trap_req = 1'b0;
    step();
    chk("arb_idle_gnt", {31'd0, pipe_csr_gnt}, 32'd0);
    chk("arb_idle_busy", {31'd0, busy}, 32'd0);
    step(); chk_write("m_status", 5'h05, 32'h1888);
    mstatus_rd = 32'h1888;
    step();
    chk("m_done_ack", {31'd0, mret_ack}, 32'd1);
    chk("m_done_tack", {31'd0, trap_ack}, 32'd0);
    chk("m_done_rv", {31'd0, redirect_valid}, 32'd1);
    chk("m_done_rpc", redirect_pc, 32'h8000_0100);
    chk("m_done_gnt", {31'd0, pipe_csr_gnt}, 32'd0);
    mret_req = 1'b0;
    step();
    chk("late_gnt", {31'd0, pipe_csr_gnt}, 32'd1);
    chk("late_we", {31'd0, csr_we}, 32'd1);
    chk("late_idx", {27'd0, csr_windex}, 32'h0C);
    chk("late_data", csr_wdata, 32'h55);
    pipe_csr_we = 1'b0;
    // reset during T_CAUSE
    mstatus_rd = 32'h8;
    step();
    trap_req = 1'b1; trap_cause = 32'h5;
    step(); step();
    chk("rst_pre_idx", {27'd0, csr_windex}, 32'h0C);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_mid");
    trap_req = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rst_no_ack", {29'd0, trap_ack, redirect_valid, busy}, 32'd0);
      step();
    end
    trap_req = 1'b1; trap_pc = 32'h8000_0200;
    step();
    chk_write("restart_epc", 5'h0B, 32'h8000_0200);
    step(); chk_write("restart_cause", 5'h0C, 32'h5);
    trap_req = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
